// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder stage driven LSB first for WIDTH cycles,
// with the carry held in a flop between bits and a registered result.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sh_a_r;
  logic [WIDTH-1:0] sh_b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt_r;
  logic             cy_r;
  logic             bit_s;
  logic             co_s;
  logic             last_s;
  logic             busy_r;
  logic             done_r;
  logic             c_out_r;

  assign bit_s  = sh_a_r[0] ^ sh_b_r[0] ^ cy_r;
  assign co_s   = (sh_a_r[0] & sh_b_r[0]) | ((sh_a_r[0] ^ sh_b_r[0]) & cy_r);
  assign last_s = (cnt_r == LAST_CNT);

  // Result shift: the new sum bit enters at the MSB (also safe for WIDTH=1).
  always_comb begin
    res_nxt_s            = res_r >> 1'b1;
    res_nxt_s[WIDTH-1]   = bit_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = SHIFT;
        else       state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = SHIFT;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, bit-serial datapath and result load on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a_r  <= '0;
      sh_b_r  <= '0;
      res_r   <= '0;
      cy_r    <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sh_a_r <= op_a;
            sh_b_r <= op_b;
            cy_r   <= c_in;
            cnt_r  <= '0;
            res_r  <= '0;
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        SHIFT: begin
          sh_a_r <= sh_a_r >> 1'b1;
          sh_b_r <= sh_b_r >> 1'b1;
          res_r  <= res_nxt_s;
          cy_r   <= co_s;
          cnt_r  <= cnt_r + CNT_ONE;
          if (last_s) begin
            sum_r   <= res_nxt_s;
            c_out_r <= co_s;
          end else begin
            sum_r   <= sum_r;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign c_out = c_out_r;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm: directed table, multi-cycle corner
// sequences, random back-to-back operations (WIDTH=8) and exhaustive WIDTH=1.
module tb_serial_adder_fsm;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start8, ci8, busy8, done8, cout8;
  logic [W-1:0] a8, b8, sum8;
  logic         start1, ci1, busy1, done1, cout1;
  logic [0:0]   a1, b1, sum1;

  int n_vec = 0;
  int n_err = 0;

  serial_adder_fsm #(.WIDTH(W)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder_fsm #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full operation on the 8-bit instance with per-cycle handshake checks.
  task automatic do_op8(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] es, input logic eco, input string name);
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~ci;
    for (int k = 1; k <= W; k++) begin
      check({name, "_shift_bd"}, {busy8, done8}, 2'b10);
      tick();
    end
    check({name, "_done_bd"}, {busy8, done8}, 2'b11);
    check({name, "_sum"}, sum8, es);
    check({name, "_cout"}, cout8, eco);
    tick();
    check({name, "_idle_bd"}, {busy8, done8}, 2'b00);
    check({name, "_hold_sum"}, {cout8, sum8}, {eco, es});
  endtask

  vec_t         vecs[6];
  int           pulses;
  bit           stable_ok;
  logic [W:0]   exp9, prev9;
  logic [W-1:0] ra, rb;
  logic         rc;
  logic [1:0]   exp2;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    #3;
    check("reset8", {busy8, done8, cout8, sum8}, 11'h000);
    check("reset1", {busy1, done1, cout1, sum1}, 4'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++)
      do_op8(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

    // start held high through SHIFT/DONE: ignored while busy, accepted again in IDLE.
    a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'hAA; b8 = 8'h55;
    pulses = 0;
    for (int k = 1; k <= W + 1; k++) begin
      if (done8) pulses++;
      if (k <= W) tick();
    end
    check("held_sum1", {cout8, sum8}, {1'b0, 8'h46});
    check("held_pulses1", pulses, 1);
    tick();
    check("held_idle", busy8, 1'b0);
    tick();
    start8 = 1'b0;
    pulses = 0;
    for (int k = 1; k <= W + 1; k++) begin
      if (done8) pulses++;
      if (k <= W) tick();
    end
    check("held_sum2", {cout8, sum8}, {1'b0, 8'hFF});
    check("held_pulses2", pulses, 1);
    tick();
    check("held_idle2", busy8, 1'b0);

    // Asynchronous reset in the middle of SHIFT.
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", {busy8, done8, cout8, sum8}, 11'h000);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done8 || busy8) pulses++;
    end
    check("midrst_quiet", pulses, 0);
    rst_n = 1'b1;
    tick();
    do_op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst");

    // Back-to-back random operations against plain integer addition.
    prev9 = {1'b0, 8'h02};
    start8 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(1, 0));
      a8 = ra; b8 = rb; ci8 = rc;
      exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      tick();
      stable_ok = 1'b1;
      for (int k = 1; k <= W; k++) begin
        a8 = W'($urandom); b8 = W'($urandom); ci8 = 1'($urandom_range(1, 0));
        if (done8 || !busy8 || {cout8, sum8} !== prev9) stable_ok = 1'b0;
        tick();
      end
      check("b2b_stable", stable_ok, 1'b1);
      check("b2b_done", {busy8, done8}, 2'b11);
      check("b2b_result", {cout8, sum8}, exp9);
      a8 = W'($urandom); b8 = W'($urandom); ci8 = 1'($urandom_range(1, 0));
      tick();
      check("b2b_idle", {busy8, done8, cout8, sum8}, {2'b00, exp9});
      prev9 = exp9;
    end
    start8 = 1'b0;
    tick();

    // WIDTH=1 instance: all operand combinations, done in cycle 2.
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); ci1 = 1'(i);
      exp2 = 2'(a1) + 2'(b1) + 2'(ci1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("w1_shift_bd", {busy1, done1}, 2'b10);
      tick();
      check("w1_done_bd", {busy1, done1}, 2'b11);
      check("w1_result", {cout1, sum1}, exp2);
      tick();
      check("w1_idle_bd", {busy1, done1}, 2'b00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
